// File: rtl/cmpl_pkg.sv
// cmpl_pkg: shared constants, entry type and index helpers for the completion writeback path.
package cmpl_pkg;
    localparam int NUM_SRC = 5;
    localparam int NUM_PORT = 4;
    localparam int BUF_DEPTH = 2;
    localparam int XLEN = 32;
    localparam int PREG_W = 6;
    localparam logic [XLEN-1:0] IDLE_PC = 32'hFFFF_FFFF;
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PORT_W = $clog2(NUM_PORT);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SRC_ALU0 = 0;
    localparam int SRC_ALU1 = 1;
    localparam int SRC_ALU2 = 2;
    localparam int SRC_MUL = 3;
    localparam int SRC_LSU = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic [PREG_W-1:0] rd;
    } cmpl_entry_t;

    localparam cmpl_entry_t IDLE_ENTRY = '{pc: IDLE_PC, data: '0, rd: '0};

    // Reduces a sum of two in-range source indices back into 0..NUM_SRC-1.
    function automatic logic [SRC_W-1:0] src_wrap(input logic [SRC_W:0] s);
        return s >= (SRC_W+1)'(NUM_SRC) ? SRC_W'(s - (SRC_W+1)'(NUM_SRC)) : s[SRC_W-1:0];
    endfunction
endpackage

// File: rtl/cmpl_wb_arbiter_if.sv
// cmpl_wb_arbiter_if: source push bus and ROB completion/wakeup ports of the writeback arbiter.
interface cmpl_wb_arbiter_if;
    import cmpl_pkg::*;
    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC*XLEN-1:0] src_pc;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [NUM_SRC*PREG_W-1:0] src_rd;
    logic [NUM_PORT-1:0] complete_valid;
    logic [XLEN-1:0] complete_pc_0, complete_pc_1, complete_pc_2, complete_pc_3;
    logic [XLEN-1:0] new_dr_data_0, new_dr_data_1, new_dr_data_2, new_dr_data_3;
    logic [PREG_W-1:0] complete_rd_0, complete_rd_1, complete_rd_2, complete_rd_3;

    modport master (
        output src_valid, src_pc, src_data, src_rd,
        input src_ready, complete_valid,
        input complete_pc_0, complete_pc_1, complete_pc_2, complete_pc_3,
        input new_dr_data_0, new_dr_data_1, new_dr_data_2, new_dr_data_3,
        input complete_rd_0, complete_rd_1, complete_rd_2, complete_rd_3
    );

    modport slave (
        input src_valid, src_pc, src_data, src_rd,
        output src_ready, complete_valid,
        output complete_pc_0, complete_pc_1, complete_pc_2, complete_pc_3,
        output new_dr_data_0, new_dr_data_1, new_dr_data_2, new_dr_data_3,
        output complete_rd_0, complete_rd_1, complete_rd_2, complete_rd_3
    );
endinterface

// File: rtl/cmpl_fifo.sv
// cmpl_fifo: small per-source FIFO of completion entries; DEPTH must be a power of two.
module cmpl_fifo
    import cmpl_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  cmpl_entry_t din,
    output cmpl_entry_t head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    cmpl_entry_t mem [DEPTH];
    logic [PW-1:0] wp, rp;

    assign head = mem[rp];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) mem[wp] <= din;
            wp <= push ? wp + PW'(1) : wp;
            rp <= pop ? rp + PW'(1) : rp;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/cmpl_wb_arbiter.sv
// cmpl_wb_arbiter: collects results from five sources and packs up to four per cycle onto the ROB ports.
module cmpl_wb_arbiter
    import cmpl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cmpl_wb_arbiter_if.slave bus
);
    logic clr;
    logic [NUM_SRC-1:0] rdy, push, grant;
    logic [CNT_W-1:0] cnt [NUM_SRC];
    cmpl_entry_t head [NUM_SRC];
    cmpl_entry_t port_e [NUM_PORT];
    cmpl_entry_t out_q [NUM_PORT];
    logic [NUM_PORT-1:0] port_v, out_v;
    logic [SRC_W-1:0] rr_ptr, rr_nxt, idx;
    logic [PORT_W:0] n;

    assign clr = rst || flush;
    assign bus.src_ready = rdy;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign rdy[i] = cnt[i] < CNT_W'(BUF_DEPTH) && !clr;
        assign push[i] = bus.src_valid[i] && rdy[i];
        cmpl_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .flush(flush),
            .push(push[i]),
            .pop(grant[i]),
            .din({bus.src_pc[XLEN*i +: XLEN], bus.src_data[XLEN*i +: XLEN], bus.src_rd[PREG_W*i +: PREG_W]}),
            .head(head[i]),
            .count(cnt[i])
        );
        // The sentinel PC would look like an idle port to the ROB.
        a_no_idle_pc: assert property (@(posedge clk) disable iff (rst)
            !(bus.src_valid[i] && bus.src_pc[XLEN*i +: XLEN] == IDLE_PC));
    end

    // Scan from rr_ptr, packing granted heads onto ports from 0 upward.
    always_comb begin
        grant = '0;
        port_v = '0;
        port_e = '{default: IDLE_ENTRY};
        rr_nxt = rr_ptr;
        n = '0;
        idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = src_wrap({1'b0, rr_ptr} + (SRC_W+1)'(k));
            if (cnt[idx] != '0 && n < (PORT_W+1)'(NUM_PORT)) begin
                grant[idx] = 1'b1;
                port_v[n[PORT_W-1:0]] = 1'b1;
                port_e[n[PORT_W-1:0]] = head[idx];
                rr_nxt = src_wrap({1'b0, idx} + (SRC_W+1)'(1));
                n = n + (PORT_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_v <= '0;
            out_q <= '{default: IDLE_ENTRY};
            rr_ptr <= '0;
        end else begin
            out_v <= port_v;
            out_q <= port_e;
            rr_ptr <= rr_nxt;
        end
    end

    assign bus.complete_valid = out_v;
    assign bus.complete_pc_0 = out_q[0].pc;
    assign bus.complete_pc_1 = out_q[1].pc;
    assign bus.complete_pc_2 = out_q[2].pc;
    assign bus.complete_pc_3 = out_q[3].pc;
    assign bus.new_dr_data_0 = out_q[0].data;
    assign bus.new_dr_data_1 = out_q[1].data;
    assign bus.new_dr_data_2 = out_q[2].data;
    assign bus.new_dr_data_3 = out_q[3].data;
    assign bus.complete_rd_0 = out_q[0].rd;
    assign bus.complete_rd_1 = out_q[1].rd;
    assign bus.complete_rd_2 = out_q[2].rd;
    assign bus.complete_rd_3 = out_q[3].rd;
endmodule
